iir_cfg_ctrl: RTL and testbench
===============================

IIR_CFG_CTRL -- requirements
Module: iir_cfg_ctrl

Interface
REQ-001 Parameter: DW, 12, data and coefficient width.
REQ-002 Parameter: TIMEOUT, 63, maximum DRAIN cycles before a forced swap.
REQ-003 Parameter: OCW, 4, outstanding-sample counter width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst_n  in  1  synchronous active-low reset.
REQ-007 Port: wr_en  in  1  shadow-register write strobe.
REQ-008 Port: wr_addr  in  3  shadow-register select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
REQ-009 Port: wr_data  in  DW  shadow-register write data.
REQ-010 Port: commit  in  1  request to apply the shadow bank to the filter.
REQ-011 Port: s_din / s_vin  in  DW / 1  upstream sample and valid.
REQ-012 Port: s_ready  out  1  upstream may present samples.
REQ-013 Port: f_din / f_vin  out  DW / 1  sample and valid to the iir.
REQ-014 Port: f_vout  in  1  iir output valid, used for drain tracking.
REQ-015 Port: b0, b1, b2, a1, a2  out  DW each  active coefficients to the iir.
REQ-016 Port: busy  out  1  high in DRAIN and SWAP.
REQ-017 Port: cmt_done  out  1  one-cycle pulse when the swap occurs.
REQ-018 Port: cfg_err  out  1  sticky error flag.

Function
REQ-019 The block SHALL implement FSM states IDLE, DRAIN and SWAP, with registered state.
REQ-020 IDLE SHALL drive s_ready=1, f_vin=s_vin and f_din=s_din combinationally.
- Samples SHALL pass with zero latency.
REQ-021 DRAIN and SWAP SHALL drive s_ready=0 and f_vin=0.
- f_din SHALL still follow s_din.
REQ-022 commit=1 in IDLE SHALL move the FSM to DRAIN on the next edge.
- An s_vin sample in that same cycle SHALL still be forwarded.
REQ-023 commit in DRAIN or SWAP SHALL be ignored, with no queuing and no error.
REQ-024 Outstanding counter (OCW bits) update rules:
- +1 when f_vin=1 and f_vout=0.
- -1 when f_vout=1 and f_vin=0.
- Unchanged when both or neither are high.
REQ-025 Counter at 2^OCW-1 with an increment SHALL saturate and set cfg_err.
REQ-026 Counter at 0 with a decrement SHALL stay 0 and set cfg_err.
REQ-027 DRAIN SHALL go to SWAP on the first cycle the counter equals 0.
- This includes the first DRAIN cycle, so an empty pipeline costs 1 DRAIN cycle.
REQ-028 DRAIN timeout counter behaviour:
- Counts cycles spent in DRAIN.
- On reaching TIMEOUT with the outstanding counter nonzero: go to SWAP, set cfg_err, clear the outstanding counter.
REQ-029 SWAP SHALL last exactly one cycle.
- On its closing edge, all five active coefficients SHALL load from the shadow bank.
- The FSM then SHALL return to IDLE.
REQ-030 cmt_done SHALL be high during the SWAP cycle only; busy = (state != IDLE).
REQ-031 wr_en=1 SHALL update the addressed shadow register on the edge in any state.
- Active coefficients SHALL never change outside SWAP.
REQ-032 A write in the SWAP cycle SHALL update the shadow register.
- The active register SHALL receive the pre-write shadow value.
REQ-033 wr_en=1 with wr_addr 5..7 SHALL write nothing and set cfg_err.
REQ-034 cfg_err SHALL be sticky, cleared only by reset.
REQ-035 Minimum commit latency: commit in cycle N (empty pipeline) gives DRAIN in N+1, SWAP/cmt_done in N+2, new coefficients and s_ready=1 in N+3.

Reset
REQ-036 rst_n=0 at an edge SHALL force the following, regardless of state:
- state=IDLE.
- Shadow and active coefficients = 0.
- Outstanding and timeout counters = 0.
- cfg_err=0.
REQ-037 During reset, s_ready=1 follows from IDLE; cmt_done=0 and busy=0.
REQ-038 Reset mid-DRAIN SHALL abandon the commit; active coefficients SHALL stay 0.

Verification
REQ-039 Basic commit: write b0=0x400, a1=0xC00, commit with an empty pipeline.
- Required: cmt_done 2 cycles after commit; b0=0x400 and a1=0xC00 from the next cycle; other coefficients 0.
REQ-040 Drain: 3 samples forwarded, commit, f_vout pulses 5, 6 and 7 cycles later.
- Required: s_ready=0 until drained; SWAP the cycle after the third f_vout; no f_vin during DRAIN.
REQ-041 Timeout: 2 samples forwarded, commit, f_vout never asserted.
- Required: SWAP after 63 DRAIN cycles; cfg_err=1; counter reads 0 afterwards.
REQ-042 Write during SWAP: write b2=0x123 in the SWAP cycle after shadow b2=0x010.
- Required: active b2=0x010; the next commit yields 0x123.
REQ-043 Errors: wr_addr=6 write, then a spurious f_vout with the counter at 0.
- Required: cfg_err set on the first event and held; no coefficient change.
REQ-044 Reset mid-DRAIN: assert rst_n=0 during DRAIN.
- Required: next cycle IDLE, s_ready=1, all coefficients 0, cfg_err=0.

Source files
------------

// File: rtl/iir_cfg_ctrl.sv
// Coefficient shadow/commit controller for a biquad IIR: collects coefficient
// writes in a shadow bank and swaps them in only once the filter pipeline is empty.
module iir_cfg_ctrl #(
    parameter int DW      = 12,
    parameter int TIMEOUT = 63,
    parameter int OCW     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [2:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          commit,
    input  logic [DW-1:0] s_din,
    input  logic          s_vin,
    output logic          s_ready,
    output logic [DW-1:0] f_din,
    output logic          f_vin,
    input  logic          f_vout,
    output logic [DW-1:0] b0,
    output logic [DW-1:0] b1,
    output logic [DW-1:0] b2,
    output logic [DW-1:0] a1,
    output logic [DW-1:0] a2,
    output logic          busy,
    output logic          cmt_done,
    output logic          cfg_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  TMO_ONE   = TW'(1);
    localparam logic [OCW-1:0] OCNT_MAX  = {OCW{1'b1}};
    localparam logic [OCW-1:0] OCNT_ZERO = {OCW{1'b0}};
    localparam logic [OCW-1:0] OCNT_ONE  = OCW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OCW-1:0]         ocnt_q, ocnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   err_q, err_d;
    logic [4:0][DW-1:0]     sh_q, sh_d;
    logic [4:0][DW-1:0]     act_q, act_d;

    logic                   s_ready_s;
    logic                   fvin_s;
    logic                   wr_err_s;
    logic                   cnt_err_s;
    logic                   tmo_err_s;
    logic [OCW-1:0]         cnt_nxt_s;

    // Sample path: transparent in IDLE, held off while a commit is in flight
    always_comb begin
        s_ready_s = 1'b1;
        fvin_s    = s_vin;
        if (state_q == ST_IDLE) begin
            s_ready_s = 1'b1;
            fvin_s    = s_vin;
        end else begin
            s_ready_s = 1'b0;
            fvin_s    = 1'b0;
        end
    end

    // Shadow bank writes; out-of-range addresses are dropped and flagged
    always_comb begin
        sh_d     = sh_q;
        wr_err_s = 1'b0;
        if (wr_en) begin
            case (wr_addr)
                3'd0:    sh_d[0] = wr_data;
                3'd1:    sh_d[1] = wr_data;
                3'd2:    sh_d[2] = wr_data;
                3'd3:    sh_d[3] = wr_data;
                3'd4:    sh_d[4] = wr_data;
                default: wr_err_s = 1'b1;
            endcase
        end else begin
            wr_err_s = 1'b0;
        end
    end

    // Outstanding-sample tracking with saturation at both ends
    always_comb begin
        cnt_nxt_s = ocnt_q;
        cnt_err_s = 1'b0;
        if (fvin_s && !f_vout) begin
            if (ocnt_q == OCNT_MAX) begin
                cnt_err_s = 1'b1;
            end else begin
                cnt_nxt_s = ocnt_q + OCNT_ONE;
            end
        end else if (f_vout && !fvin_s) begin
            if (ocnt_q == OCNT_ZERO) begin
                cnt_err_s = 1'b1;
            end else begin
                cnt_nxt_s = ocnt_q - OCNT_ONE;
            end
        end else begin
            cnt_nxt_s = ocnt_q;
        end
    end

    // Commit sequencing; drain completes on the cycle the last output retires
    always_comb begin
        state_d   = state_q;
        ocnt_d    = cnt_nxt_s;
        tmo_d     = '0;
        act_d     = act_q;
        tmo_err_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (cnt_nxt_s == OCNT_ZERO) begin
                    state_d = ST_SWAP;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_SWAP;
                    tmo_err_s = 1'b1;
                    ocnt_d    = OCNT_ZERO;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            ST_SWAP: begin
                act_d   = sh_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        err_d = err_q | wr_err_s | cnt_err_s | tmo_err_s;
    end

    // State and register bank update with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ocnt_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            sh_q    <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            ocnt_q  <= ocnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            sh_q    <= sh_d;
            act_q   <= act_d;
        end
    end

    assign s_ready  = s_ready_s;
    assign f_vin    = fvin_s;
    assign f_din    = s_din;
    assign b0       = act_q[0];
    assign b1       = act_q[1];
    assign b2       = act_q[2];
    assign a1       = act_q[3];
    assign a2       = act_q[4];
    assign busy     = (state_q != ST_IDLE);
    assign cmt_done = (state_q == ST_SWAP);
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_iir_cfg_ctrl.sv
// Directed bench for iir_cfg_ctrl: commit timing, drain, timeout, swap-cycle
// writes, error flagging and reset behaviour.
module tb_iir_cfg_ctrl;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          commit;
    logic [DW-1:0] s_din;
    logic          s_vin;
    logic          s_ready;
    logic [DW-1:0] f_din;
    logic          f_vin;
    logic          f_vout;
    logic [DW-1:0] b0, b1, b2, a1, a2;
    logic          busy;
    logic          cmt_done;
    logic          cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iir_cfg_ctrl #(.DW(DW), .TIMEOUT(63), .OCW(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .s_din(s_din), .s_vin(s_vin),
        .s_ready(s_ready), .f_din(f_din), .f_vin(f_vin), .f_vout(f_vout),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
        .busy(busy), .cmt_done(cmt_done), .cfg_err(cfg_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 12'h000;
        commit = 1'b0; f_vout = 1'b0; s_vin = 1'b1; s_din = 12'hABC;
        step(); step();
        n_tests++; if ({s_ready, busy, cmt_done, cfg_err} !== 4'b1000) begin n_fail++;
            $display("FAIL reset_flags: got %b expected %b", {s_ready, busy, cmt_done, cfg_err}, 4'b1000); end
        n_tests++; if ({b0, b1, b2, a1, a2} !== 60'h0) begin n_fail++;
            $display("FAIL reset_coefs: got %h expected %h", {b0, b1, b2, a1, a2}, 60'h0); end
        n_tests++; if (f_vin !== 1'b1 || f_din !== 12'hABC) begin n_fail++;
            $display("FAIL reset_fwd: got %b/%h expected 1/abc", f_vin, f_din); end
        rst_n = 1'b1; s_vin = 1'b0;
        step();
    endtask

    task automatic test_passthrough();
        s_vin = 1'b1; s_din = 12'h5A5; f_vout = 1'b1;
        #1;
        n_tests++; if ({s_ready, f_vin} !== 2'b11 || f_din !== 12'h5A5) begin n_fail++;
            $display("FAIL pass_valid: got %b%b/%h expected 11/5a5", s_ready, f_vin, f_din); end
        step();
        s_vin = 1'b0; s_din = 12'h3C3; f_vout = 1'b0;
        #1;
        n_tests++; if (f_vin !== 1'b0 || f_din !== 12'h3C3) begin n_fail++;
            $display("FAIL pass_idle: got %b/%h expected 0/3c3", f_vin, f_din); end
        step();
    endtask

    task automatic test_basic_commit();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 12'h400; step();
        wr_addr = 3'd3; wr_data = 12'hC00; step();
        wr_en = 1'b0; commit = 1'b1;
        #1;
        n_tests++; if ({b0, b1, b2, a1, a2} !== 60'h0 || s_ready !== 1'b1) begin n_fail++;
            $display("FAIL basic_pre: got %h/%b expected 0/1", {b0, b1, b2, a1, a2}, s_ready); end
        step();
        commit = 1'b0;
        n_tests++; if ({busy, s_ready, cmt_done} !== 3'b100) begin n_fail++;
            $display("FAIL basic_n1: got %b expected %b", {busy, s_ready, cmt_done}, 3'b100); end
        step();
        n_tests++; if ({busy, cmt_done} !== 2'b11 || b0 !== 12'h000) begin n_fail++;
            $display("FAIL basic_n2: got %b/%h expected 11/000", {busy, cmt_done}, b0); end
        step();
        n_tests++; if ({busy, s_ready, cmt_done} !== 3'b010) begin n_fail++;
            $display("FAIL basic_n3_flags: got %b expected %b", {busy, s_ready, cmt_done}, 3'b010); end
        n_tests++; if ({b0, b1, b2, a1, a2} !== {12'h400, 12'h000, 12'h000, 12'hC00, 12'h000}) begin n_fail++;
            $display("FAIL basic_n3_coefs: got %h expected 400000000c00000", {b0, b1, b2, a1, a2}); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 3; i++) begin
            s_vin = 1'b1; s_din = 12'h100 | 12'(i);
            #1;
            n_tests++; if (f_vin !== 1'b1) begin n_fail++;
                $display("FAIL drain_fwd i=%0d: got %b expected 1", i, f_vin); end
            step();
        end
        s_vin = 1'b0; commit = 1'b1; step();
        commit = 1'b0; s_vin = 1'b1; s_din = 12'h777;
        for (int k = 1; k <= 7; k++) begin
            f_vout = (k >= 5);
            #1;
            n_tests++; if ({busy, s_ready, f_vin, cmt_done} !== 4'b1000 || f_din !== 12'h777) begin n_fail++;
                $display("FAIL drain_hold k=%0d: got %b/%h expected 1000/777", k, {busy, s_ready, f_vin, cmt_done}, f_din); end
            step();
        end
        f_vout = 1'b0;
        #1;
        n_tests++; if ({cmt_done, s_ready, f_vin} !== 3'b100) begin n_fail++;
            $display("FAIL drain_swap: got %b expected %b", {cmt_done, s_ready, f_vin}, 3'b100); end
        step();
        n_tests++; if ({cmt_done, s_ready, cfg_err} !== 3'b010) begin n_fail++;
            $display("FAIL drain_done: got %b expected %b", {cmt_done, s_ready, cfg_err}, 3'b010); end
        s_vin = 1'b0;
        step();
    endtask

    task automatic test_write_swap();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 12'h010; step();
        wr_en = 1'b0; commit = 1'b1; step();
        commit = 1'b0; step();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 12'h123;
        #1;
        n_tests++; if (cmt_done !== 1'b1) begin n_fail++;
            $display("FAIL wswap_cycle: got %b expected 1", cmt_done); end
        step();
        wr_en = 1'b0;
        n_tests++; if (b2 !== 12'h010) begin n_fail++;
            $display("FAIL wswap_old: got %h expected 010", b2); end
        commit = 1'b1; step();
        commit = 1'b0; step();
        n_tests++; if (cmt_done !== 1'b1) begin n_fail++;
            $display("FAIL wswap_cmt2: got %b expected 1", cmt_done); end
        step();
        n_tests++; if ({b0, b1, b2, a1, a2} !== {12'h400, 12'h000, 12'h123, 12'hC00, 12'h000}) begin n_fail++;
            $display("FAIL wswap_new: got %h expected 400000123c00000", {b0, b1, b2, a1, a2}); end
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++;
            $display("FAIL wswap_err: got %b expected 0", cfg_err); end
    endtask

    task automatic test_errors();
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 12'hFFF;
        #1;
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++;
            $display("FAIL err_before: got %b expected 0", cfg_err); end
        step();
        wr_en = 1'b0;
        n_tests++; if (cfg_err !== 1'b1) begin n_fail++;
            $display("FAIL err_badaddr: got %b expected 1", cfg_err); end
        f_vout = 1'b1; step();
        f_vout = 1'b0; step();
        n_tests++; if (cfg_err !== 1'b1) begin n_fail++;
            $display("FAIL err_sticky: got %b expected 1", cfg_err); end
        commit = 1'b1; step();
        commit = 1'b0; step();
        n_tests++; if (cmt_done !== 1'b1) begin n_fail++;
            $display("FAIL err_cnt_zero: got %b expected 1", cmt_done); end
        step();
        n_tests++; if ({b0, b1, b2, a1, a2} !== {12'h400, 12'h000, 12'h123, 12'hC00, 12'h000}) begin n_fail++;
            $display("FAIL err_coefs: got %h expected 400000123c00000", {b0, b1, b2, a1, a2}); end
    endtask

    task automatic test_reset_drain();
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++;
            $display("FAIL rstd_clear: got %b expected 0", cfg_err); end
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 12'h111; step();
        wr_en = 1'b0; s_vin = 1'b1; step();
        s_vin = 1'b0; commit = 1'b1; step();
        commit = 1'b0; step();
        n_tests++; if ({busy, cmt_done} !== 2'b10) begin n_fail++;
            $display("FAIL rstd_draining: got %b expected 10", {busy, cmt_done}); end
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        n_tests++; if ({busy, s_ready, cmt_done, cfg_err} !== 4'b0100 || {b0, b1, b2, a1, a2} !== 60'h0) begin n_fail++;
            $display("FAIL rstd_state: got %b/%h expected 0100/0", {busy, s_ready, cmt_done, cfg_err}, {b0, b1, b2, a1, a2}); end
        for (int j = 0; j < 3; j++) begin
            step();
            n_tests++; if (cmt_done !== 1'b0 || b0 !== 12'h000) begin n_fail++;
                $display("FAIL rstd_abandon j=%0d: got %b/%h expected 0/000", j, cmt_done, b0); end
        end
        commit = 1'b1; step();
        commit = 1'b0; step(); step();
        n_tests++; if (b0 !== 12'h000) begin n_fail++;
            $display("FAIL rstd_shadow: got %h expected 000", b0); end
    endtask

    task automatic test_timeout();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 12'h7FF; step();
        wr_en = 1'b0; s_vin = 1'b1; step(); step();
        s_vin = 1'b0; commit = 1'b1; step();
        commit = 1'b0;
        for (int k = 1; k <= 63; k++) begin
            n_tests++; if ({busy, cmt_done, cfg_err} !== 3'b100) begin n_fail++;
                $display("FAIL tmo_drain k=%0d: got %b expected 100", k, {busy, cmt_done, cfg_err}); end
            step();
        end
        n_tests++; if ({cmt_done, cfg_err} !== 2'b11) begin n_fail++;
            $display("FAIL tmo_swap: got %b expected 11", {cmt_done, cfg_err}); end
        step();
        n_tests++; if (busy !== 1'b0 || {b0, b1, b2, a1, a2} !== {48'h0, 12'h7FF}) begin n_fail++;
            $display("FAIL tmo_coefs: got %b/%h expected 0/7ff", busy, {b0, b1, b2, a1, a2}); end
        commit = 1'b1; step();
        commit = 1'b0; step();
        n_tests++; if ({cmt_done, cfg_err} !== 2'b11) begin n_fail++;
            $display("FAIL tmo_cnt_cleared: got %b expected 11", {cmt_done, cfg_err}); end
        step();
    endtask

    task automatic test_saturate();
        rst_n = 1'b0; step();
        rst_n = 1'b1; s_vin = 1'b1;
        for (int i = 0; i < 15; i++) step();
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++;
            $display("FAIL sat_at_max: got %b expected 0", cfg_err); end
        step();
        s_vin = 1'b0;
        n_tests++; if (cfg_err !== 1'b1) begin n_fail++;
            $display("FAIL sat_overflow: got %b expected 1", cfg_err); end
        commit = 1'b1; step();
        commit = 1'b0; f_vout = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            n_tests++; if ({busy, cmt_done} !== 2'b10) begin n_fail++;
                $display("FAIL sat_drain k=%0d: got %b expected 10", k, {busy, cmt_done}); end
            step();
        end
        f_vout = 1'b0;
        n_tests++; if (cmt_done !== 1'b1) begin n_fail++;
            $display("FAIL sat_swap: got %b expected 1", cmt_done); end
        step();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_basic_commit();
        test_drain();
        test_write_swap();
        test_errors();
        test_reset_drain();
        test_timeout();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
